cdb_arbiter: RTL

Parametrised common data bus for the GPU back end. It accepts writeback results from `NUM_SRC` execution units (ALU, MEM, and later SFU/texture) through per-source valid/ready queues. A round-robin arbiter grants one result per cycle. The granted result goes onto a registered broadcast port that drives register-file writeback in the RAU and scoreboard clear. Unlike the two-input fixed-priority combinational CDB, it has per-source buffering and backpressure, and it can carry scoreboard-clear-only entries that have no register write.

---
 rtl/cdb_pkg.sv | 27 ++
 rtl/cdb_arbiter_if.sv | 44 ++++
 rtl/cdb_src_fifo.sv | 50 +++++
 rtl/cdb_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared constants and the default-width entry layout for the common data bus.
// entry_width() keeps parametrised instances consistent with the field order below.
package cdb_pkg;
  localparam int CDB_WADDR_W = 3;
  localparam int CDB_INSTR_W = 32;
  localparam int CDB_DST_W   = 5;

  localparam int DEF_LANES  = 8;
  localparam int DEF_LANE_W = 32;
  localparam int DEF_WARP_W = 3;
  localparam int DEF_SCB_W  = 2;

  typedef struct packed {
    logic                             regwrite;
    logic                             clear;
    logic [DEF_WARP_W-1:0]            warp;
    logic [CDB_WADDR_W-1:0]           waddr;
    logic [DEF_LANES*DEF_LANE_W-1:0]  data;
    logic [CDB_INSTR_W-1:0]           instr;
    logic [DEF_LANES-1:0]             mask;
    logic [DEF_SCB_W-1:0]             scbid;
  } cdb_entry_t;

  function automatic int entry_width(int lanes, int lane_w, int warp_w, int scb_w);
    return 2 + warp_w + CDB_WADDR_W + lanes * lane_w + CDB_INSTR_W + lanes + scb_w;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-facing queues plus the registered broadcast port of the common data bus.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int LANES   = 8,
  parameter int LANE_W  = 32,
  parameter int WARP_W  = 3,
  parameter int SCB_W   = 2
);
  logic [NUM_SRC-1:0]              src_valid;
  logic [NUM_SRC-1:0]              src_ready;
  logic [NUM_SRC-1:0]              src_regwrite;
  logic [NUM_SRC-1:0]              src_clear;
  logic [NUM_SRC*WARP_W-1:0]       src_warp;
  logic [NUM_SRC*5-1:0]            src_dst;
  logic [NUM_SRC*LANES*LANE_W-1:0] src_data;
  logic [NUM_SRC*32-1:0]           src_instr;
  logic [NUM_SRC*LANES-1:0]        src_mask;
  logic [NUM_SRC*SCB_W-1:0]        src_scbid;
  logic [NUM_SRC-1:0]              src_grant;

  logic                            cdb_valid;
  logic                            cdb_regwrite;
  logic [WARP_W-1:0]               cdb_warp;
  logic [2:0]                      cdb_waddr;
  logic [LANES*LANE_W-1:0]         cdb_data;
  logic [31:0]                     cdb_instr;
  logic [LANES-1:0]                cdb_mask;
  logic                            cdb_clear_valid;
  logic [SCB_W-1:0]                cdb_clear_scbid;

  modport master (
    output src_valid, src_regwrite, src_clear, src_warp, src_dst, src_data,
           src_instr, src_mask, src_scbid,
    input  src_ready, src_grant, cdb_valid, cdb_regwrite, cdb_warp, cdb_waddr,
           cdb_data, cdb_instr, cdb_mask, cdb_clear_valid, cdb_clear_scbid
  );

  modport slave (
    input  src_valid, src_regwrite, src_clear, src_warp, src_dst, src_data,
           src_instr, src_mask, src_scbid,
    output src_ready, src_grant, cdb_valid, cdb_regwrite, cdb_warp, cdb_waddr,
           cdb_data, cdb_instr, cdb_mask, cdb_clear_valid, cdb_clear_scbid
  );
endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source entry queue, DEPTH deep; head is readable the cycle after the first push.
// full/empty come straight from the registered count; push when full and pop when empty are ignored.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common data bus: per-source queues, one registered broadcast per cycle, 2-cycle min latency.
// src_ready is the registered not-full of each queue; the broadcast side has no backpressure.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int LANES   = 8,
  parameter int LANE_W  = 32,
  parameter int WARP_W  = 3,
  parameter int SCB_W   = 2
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int DATA_W = LANES * LANE_W;
  localparam int PTR_W  = $clog2(NUM_SRC);
  localparam int EW     = entry_width(LANES, LANE_W, WARP_W, SCB_W);

  typedef struct packed {
    logic                   regwrite;
    logic                   clear;
    logic [WARP_W-1:0]      warp;
    logic [CDB_WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]      data;
    logic [CDB_INSTR_W-1:0] instr;
    logic [LANES-1:0]       mask;
    logic [SCB_W-1:0]       scbid;
  } entry_t;

  entry_t               push_entry [NUM_SRC];
  entry_t               head       [NUM_SRC];
  logic [NUM_SRC-1:0]   full;
  logic [NUM_SRC-1:0]   empty;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   grant;
  logic [2*NUM_SRC-1:0] req2;
  logic [2*NUM_SRC-1:0] rot2;
  logic [PTR_W:0]       offset;
  logic [PTR_W:0]       idx_sum;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_nxt;
  logic                 grant_any;
  entry_t               out_q;
  logic                 out_vld;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [1:0] unused_dst_hi;

    assign unused_dst_hi  = bus.src_dst[gi*5+3 +: 2];
    assign push_entry[gi] = '{
      regwrite: bus.src_regwrite[gi],
      clear:    bus.src_clear[gi],
      warp:     bus.src_warp[gi*WARP_W +: WARP_W],
      waddr:    bus.src_dst[gi*5 +: CDB_WADDR_W],
      data:     bus.src_data[gi*DATA_W +: DATA_W],
      instr:    bus.src_instr[gi*CDB_INSTR_W +: CDB_INSTR_W],
      mask:     bus.src_mask[gi*LANES +: LANES],
      scbid:    bus.src_scbid[gi*SCB_W +: SCB_W]
    };
    // Entries with neither flag set carry no work, so they are accepted and discarded.
    assign push[gi] = bus.src_valid[gi] & bus.src_ready[gi] &
                      (bus.src_regwrite[gi] | bus.src_clear[gi]);
    assign bus.src_ready[gi] = ~full[gi] & ~rst;

    cdb_src_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[gi]),
      .push_data (push_entry[gi]),
      .pop       (grant[gi]),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .head      (head[gi])
    );
  end

  assign req  = ~empty & {NUM_SRC{~rst}};
  assign req2 = {req, req};
  assign rot2 = req2 >> rr_ptr;

  // Rotating the doubled request vector puts rr_ptr at bit 0; the lowest set bit is the winner.
  always_comb begin
    grant_any = 1'b0;
    offset    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot2[k]) begin
        grant_any = 1'b1;
        offset    = (PTR_W+1)'(k);
      end
    end
    idx_sum = {1'b0, rr_ptr} + offset;
    if (idx_sum >= (PTR_W+1)'(NUM_SRC)) idx_sum = idx_sum - (PTR_W+1)'(NUM_SRC);
    grant_idx = idx_sum[PTR_W-1:0];
    rr_nxt    = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
    grant     = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      out_vld <= grant_any;
      if (grant_any) begin
        out_q  <= head[grant_idx];
        rr_ptr <= rr_nxt;
      end
    end
  end

  assign bus.src_grant       = grant;
  assign bus.cdb_valid       = out_vld;
  assign bus.cdb_regwrite    = out_vld & out_q.regwrite;
  assign bus.cdb_warp        = out_q.warp;
  assign bus.cdb_waddr       = out_q.waddr;
  assign bus.cdb_data        = out_q.data;
  assign bus.cdb_instr       = out_q.instr;
  assign bus.cdb_mask        = out_q.mask;
  assign bus.cdb_clear_valid = out_vld & out_q.clear;
  assign bus.cdb_clear_scbid = out_q.scbid;
endmodule
